// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative unsigned multiply/divide unit feeding the register file
// writeback path. Each operation produces one result bit per clock. A final
// edge then registers the result and raises a one-cycle write strobe.
module seq_muldiv #(
    parameter int WIDTH = 16,
    parameter int SELW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SELW-1:0]  dest,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] rd_data,
    output logic [SELW-1:0]  rd_sel,
    output logic             wrt,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] opnd_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [SELW-1:0]  sel_r;
    logic [CW-1:0]    count;
    logic             wrt_r;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;

    // One iteration step. For multiplies hi:lo is the running product, with the
    // multiplier shifted out of lo. For divides hi is the partial remainder
    // and lo shifts the dividend out while the quotient bits shift in.
    always_comb begin
        mul_sum   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : '0);
        div_shift = {hi_r, lo_r[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd_r};
        hi_n      = mul_sum[WIDTH:1];
        lo_n      = {mul_sum[0], lo_r[WIDTH-1:1]};
        if (op_r[1]) begin
            if (!div_diff[WIDTH+1]) begin
                hi_n = div_diff[WIDTH-1:0];
            end else begin
                hi_n = div_shift[WIDTH-1:0];
            end
            lo_n = {lo_r[WIDTH-2:0], ~div_diff[WIDTH+1]};
        end
    end

    // Control FSM with registered outputs. There are 16 iteration edges.
    // One more edge moves the selected result half into the output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            op_r    <= '0;
            opnd_r  <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
            sel_r   <= '0;
            count   <= '0;
            busy    <= 1'b0;
            wrt_r   <= 1'b0;
            dbz     <= 1'b0;
            rd_data <= '0;
            rd_sel  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wrt_r <= 1'b0;
                    if (start && !flush) begin
                        op_r   <= op;
                        opnd_r <= op[1] ? b : a;
                        lo_r   <= op[1] ? a : b;
                        hi_r   <= '0;
                        sel_r  <= dest;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (count == CW'(WIDTH)) begin
                        rd_data <= op_r[0] ? hi_r : lo_r;
                        rd_sel  <= sel_r;
                        dbz     <= op_r[1] && (opnd_r == '0);
                        wrt_r   <= 1'b1;
                        state   <= DONE;
                    end else begin
                        hi_r  <= hi_n;
                        lo_r  <= lo_n;
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    wrt_r <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    wrt_r <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // The register file writes on the falling edge. A flush raised during the
    // DONE cycle must stop that write, so the strobe is qualified here.
    always_comb begin
        wrt = wrt_r && !flush;
    end

endmodule

// File: tb/tb_seq_muldiv.sv
// tb_seq_muldiv: directed self-checking bench for seq_muldiv.
module tb_seq_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  dest;
    logic        flush;
    logic        busy;
    logic [15:0] rd_data;
    logic [3:0]  rd_sel;
    logic        wrt;
    logic        dbz;

    int checks;
    int failures;

    seq_muldiv #(.WIDTH(16), .SELW(4)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .dest(dest),
        .flush(flush),
        .busy(busy),
        .rd_data(rd_data),
        .rd_sel(rd_sel),
        .wrt(wrt),
        .dbz(dbz)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Launch one operation and wait for its write strobe.
    // Latency is counted in rising edges after the accept edge.
    task automatic applyStimulus(input logic [1:0] o, input logic [15:0] x,
                                 input logic [15:0] y, input logic [3:0] d,
                                 output logic [15:0] data, output logic [3:0] sel,
                                 output logic dz, output int lat);
        data = '0;
        sel  = '0;
        dz   = 1'b0;
        lat  = -1;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        dest  = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (wrt === 1'b1) begin
                lat  = n;
                data = rd_data;
                sel  = rd_sel;
                dz   = dbz;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        dest  = '0;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, wrt, dbz, rd_data, rd_sel} !== 23'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs actual busy=%b wrt=%b dbz=%b data=%h sel=%h required all zero",
                     busy, wrt, dbz, rd_data, rd_sel);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_mul();
        logic [15:0] data;
        logic [3:0]  sel;
        logic        dz;
        int          lat;
        applyStimulus(2'b00, 16'd7, 16'd6, 4'd3, data, sel, dz, lat);
        checks++;
        if (lat !== 17) begin
            failures++;
            $display("[TB] FAIL mul_latency actual=%0d required=17", lat);
        end
        checks++;
        if (data !== 16'h002A || sel !== 4'd3 || dz !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mul_7x6 actual data=%h sel=%0d dbz=%b required data=002a sel=3 dbz=0",
                     data, sel, dz);
        end
        checks++;
        if (busy !== 1'b0 || wrt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mul_idle_after actual busy=%b wrt=%b required 0 0", busy, wrt);
        end
        checks++;
        if (rd_data !== 16'h002A) begin
            failures++;
            $display("[TB] FAIL mul_hold actual=%h required=002a", rd_data);
        end
        applyStimulus(2'b00, 16'hFFFF, 16'hFFFF, 4'd1, data, sel, dz, lat);
        checks++;
        if (lat !== 17 || data !== 16'h0001) begin
            failures++;
            $display("[TB] FAIL mul_ffff actual data=%h lat=%0d required data=0001 lat=17", data, lat);
        end
        applyStimulus(2'b01, 16'hFFFF, 16'hFFFF, 4'd2, data, sel, dz, lat);
        checks++;
        if (lat !== 17 || data !== 16'hFFFE || sel !== 4'd2 || dz !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mulh_ffff actual data=%h sel=%0d dbz=%b lat=%0d required fffe 2 0 17",
                     data, sel, dz, lat);
        end
    endtask

    task automatic test_div();
        logic [15:0] data;
        logic [3:0]  sel;
        logic        dz;
        int          lat;
        applyStimulus(2'b10, 16'd100, 16'd7, 4'd4, data, sel, dz, lat);
        checks++;
        if (lat !== 17 || data !== 16'h000E || sel !== 4'd4 || dz !== 1'b0) begin
            failures++;
            $display("[TB] FAIL divu_100_7 actual data=%h sel=%0d dbz=%b lat=%0d required 000e 4 0 17",
                     data, sel, dz, lat);
        end
        applyStimulus(2'b11, 16'd100, 16'd7, 4'd5, data, sel, dz, lat);
        checks++;
        if (lat !== 17 || data !== 16'h0002 || dz !== 1'b0) begin
            failures++;
            $display("[TB] FAIL remu_100_7 actual data=%h dbz=%b lat=%0d required 0002 0 17", data, dz, lat);
        end
        applyStimulus(2'b10, 16'h8000, 16'd1, 4'd6, data, sel, dz, lat);
        checks++;
        if (lat !== 17 || data !== 16'h8000) begin
            failures++;
            $display("[TB] FAIL divu_8000_1 actual data=%h lat=%0d required 8000 17", data, lat);
        end
    endtask

    task automatic test_div_by_zero();
        logic [15:0] data;
        logic [3:0]  sel;
        logic        dz;
        int          lat;
        applyStimulus(2'b10, 16'h1234, 16'd0, 4'd7, data, sel, dz, lat);
        checks++;
        if (lat !== 17 || data !== 16'hFFFF || dz !== 1'b1) begin
            failures++;
            $display("[TB] FAIL divu_dbz actual data=%h dbz=%b lat=%0d required ffff 1 17", data, dz, lat);
        end
        applyStimulus(2'b11, 16'h1234, 16'd0, 4'd8, data, sel, dz, lat);
        checks++;
        if (lat !== 17 || data !== 16'h1234 || sel !== 4'd8 || dz !== 1'b1) begin
            failures++;
            $display("[TB] FAIL remu_dbz actual data=%h sel=%0d dbz=%b lat=%0d required 1234 8 1 17",
                     data, sel, dz, lat);
        end
    endtask

    task automatic test_busy_start();
        int          pulses;
        logic [15:0] data;
        logic [3:0]  sel;
        pulses = 0;
        data   = '0;
        sel    = '0;
        @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        a     = 16'd100;
        b     = 16'd7;
        dest  = 4'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL busy_after_accept actual=%b required=1", busy);
        end
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        a     = 16'd50;
        b     = 16'd3;
        dest  = 4'd9;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (wrt === 1'b1) begin
                pulses++;
                data = rd_data;
                sel  = rd_sel;
            end
        end
        checks++;
        if (pulses !== 1 || data !== 16'h000E || sel !== 4'd5) begin
            failures++;
            $display("[TB] FAIL busy_start actual pulses=%0d data=%h sel=%0d required 1 000e 5",
                     pulses, data, sel);
        end
    endtask

    task automatic test_abort();
        int          pulses;
        logic [15:0] data;
        logic [3:0]  sel;
        logic        dz;
        int          lat;
        // Asynchronous reset while the RUN counter sits at 5
        pulses = 0;
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        a     = 16'd9;
        b     = 16'd9;
        dest  = 4'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || wrt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_abort actual busy=%b wrt=%b required 0 0", busy, wrt);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (wrt === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("[TB] FAIL reset_abort_nowrite actual pulses=%0d required 0", pulses);
        end
        applyStimulus(2'b00, 16'd9, 16'd9, 4'd10, data, sel, dz, lat);
        checks++;
        if (lat !== 17 || data !== 16'h0051 || sel !== 4'd10) begin
            failures++;
            $display("[TB] FAIL after_reset_op actual data=%h sel=%0d lat=%0d required 0051 10 17",
                     data, sel, lat);
        end

        // Flush raised during the DONE cycle
        pulses = 0;
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        a     = 16'h1000;
        b     = 16'h0010;
        dest  = 4'd11;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        if (wrt === 1'b1) pulses++;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || wrt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_done_idle actual busy=%b wrt=%b required 0 0", busy, wrt);
        end
        for (int n = 0; n < 25; n++) begin
            @(posedge clk);
            #1;
            if (wrt === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("[TB] FAIL flush_done_nowrite actual pulses=%0d required 0", pulses);
        end
        applyStimulus(2'b01, 16'h1000, 16'h0010, 4'd11, data, sel, dz, lat);
        checks++;
        if (lat !== 17 || data !== 16'h0001 || sel !== 4'd11) begin
            failures++;
            $display("[TB] FAIL after_flush_op actual data=%h sel=%0d lat=%0d required 0001 11 17",
                     data, sel, lat);
        end

        // Flush and start together in IDLE: nothing accepted
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = 2'b00;
        a     = 16'd2;
        b     = 16'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_start_idle actual busy=%b required 0", busy);
        end
    endtask

    // Scenario sequence followed by the summary line
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_mul();
        test_div();
        test_div_by_zero();
        test_busy_start();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
